ex_multdiv_arbiter: RTL

EX_MULTDIV_ARBITER -- requirements
Module: ex_multdiv_arbiter

---
 rtl/ex_multdiv_arbiter_if.sv | 36 +++
 rtl/ex_multdiv_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/ex_multdiv_arbiter_if.sv
// rtl/ex_multdiv_arbiter_if.sv - requester, response and mul/div unit signals of the arbiter
interface ex_multdiv_arbiter_if;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][1:0]  req_op_i;
    logic [1:0][1:0]  req_signed_i;
    logic [1:0][31:0] req_a_i;
    logic [1:0][31:0] req_b_i;
    logic [1:0]       rsp_valid_o;
    logic [1:0]       rsp_ready_i;
    logic [31:0]      rsp_result_o;
    logic             rsp_err_o;
    logic             md_en_o;
    logic [1:0]       md_op_o;
    logic [1:0]       md_signed_o;
    logic [31:0]      md_a_o;
    logic [31:0]      md_b_o;
    logic             md_valid_i;
    logic [31:0]      md_result_i;
    logic             md_ready_o;
    logic             busy_o;

    modport slave (
        input  req_valid_i, req_op_i, req_signed_i, req_a_i, req_b_i,
        input  rsp_ready_i, md_valid_i, md_result_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
        output md_en_o, md_op_o, md_signed_o, md_a_o, md_b_o, md_ready_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_i, req_signed_i, req_a_i, req_b_i,
        output rsp_ready_i, md_valid_i, md_result_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
        input  md_en_o, md_op_o, md_signed_o, md_a_o, md_b_o, md_ready_o, busy_o
    );
endinterface

// File: rtl/ex_multdiv_arbiter.sv
// rtl/ex_multdiv_arbiter.sv - two-requester arbiter for a shared mul/div unit with watchdog abort
// EX_MULTDIV_ARB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module ex_multdiv_arbiter #(
    parameter int unsigned WatchdogCycles = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ex_multdiv_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam logic [7:0] WdLast = 8'(WatchdogCycles - 1);

    state_e      state;
    logic        grant_idx;
    logic [7:0]  wd_cnt;
    logic [1:0]  op_q;
    logic [1:0]  signed_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic        err_q;
    logic        md_en_q;
    logic [1:0]  rsp_valid_q;
    logic        winner;
    logic        accept;

`ifdef EX_MULTDIV_ARB_RR_EN
    logic rr_ptr;
    always_comb winner = bus.req_valid_i[rr_ptr] ? rr_ptr : ~rr_ptr;
`else
    always_comb winner = ~bus.req_valid_i[0];
`endif

    // Grant is combinational in IDLE and suppressed while reset is asserted.
    assign accept          = (state == IDLE) && (|bus.req_valid_i) && !rst_i;
    assign bus.req_ready_o = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.md_ready_o  = (state == BUSY) && bus.md_valid_i;
    assign bus.md_en_o     = md_en_q;
    assign bus.md_op_o     = op_q;
    assign bus.md_signed_o = signed_q;
    assign bus.md_a_o      = a_q;
    assign bus.md_b_o      = b_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_result_o = result_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            grant_idx   <= 1'b0;
            wd_cnt      <= 8'd0;
            op_q        <= 2'd0;
            signed_q    <= 2'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            result_q    <= 32'd0;
            err_q       <= 1'b0;
            md_en_q     <= 1'b0;
            rsp_valid_q <= 2'b00;
`ifdef EX_MULTDIV_ARB_RR_EN
            rr_ptr      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid_i) begin
                        state     <= BUSY;
                        grant_idx <= winner;
                        op_q      <= bus.req_op_i[winner];
                        signed_q  <= bus.req_signed_i[winner];
                        a_q       <= bus.req_a_i[winner];
                        b_q       <= bus.req_b_i[winner];
                        wd_cnt    <= 8'd0;
                        md_en_q   <= 1'b1;
`ifdef EX_MULTDIV_ARB_RR_EN
                        rr_ptr    <= ~winner;
`endif
                    end
                end
                BUSY: begin
                    // A unit result in the expiry cycle takes precedence over the abort.
                    if (bus.md_valid_i) begin
                        result_q    <= bus.md_result_i;
                        err_q       <= 1'b0;
                        md_en_q     <= 1'b0;
                        rsp_valid_q <= grant_idx ? 2'b10 : 2'b01;
                        state       <= RESP;
                    end else if (wd_cnt == WdLast) begin
                        result_q    <= 32'd0;
                        err_q       <= 1'b1;
                        md_en_q     <= 1'b0;
                        rsp_valid_q <= grant_idx ? 2'b10 : 2'b01;
                        state       <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i[grant_idx]) begin
                        rsp_valid_q <= 2'b00;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
